// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, unsigned or two's-complement.
// Optional SEQ_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sign_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand, acc, term, acc_nxt;
  logic [WIDTH-1:0]   mplier, rem;
  logic               sgn, bit_i, sub, last;
  logic [CW-1:0]      cnt;

  always_comb begin
    rem     = mplier >> cnt;
    bit_i   = rem[0];
    term    = mcand << cnt;
    // The MSB of a two's-complement multiplier carries weight -2^(WIDTH-1).
    sub     = sgn && bit_i && (cnt == CW'(WIDTH-1));
    acc_nxt = !bit_i ? acc : (sub ? acc - term : acc + term);
    last    = (cnt == CW'(WIDTH-1));
`ifdef SEQ_MULT_EARLY_EXIT_EN
    last    = last || (rem == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      p      <= '0;
      acc    <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      sgn    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= sign_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
          mplier <= b;
          sgn    <= sign_mode;
          acc    <= '0;
          cnt    <= '0;
          p      <= '0;
          state  <= BUSY;
        end
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            p     <= acc_nxt;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);
endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: WIDTH=8 and WIDTH=16 instances against an arithmetic model.
module tb_seq_mult_param;
  logic        clk, reset;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  int checks = 0, errors = 0;

  seq_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sign_mode(sm8), .a(a8), .b(b8),
    .p(p8), .busy(busy8), .done(done8));
  seq_mult_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .sign_mode(sm16), .a(a16), .b(b16),
    .p(p16), .busy(busy16), .done(done16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact product modulo 2^(2w), from signed/unsigned integer interpretation.
  function automatic logic [63:0] ref_prod(int w, logic [31:0] x, logic [31:0] y, bit s);
    longint sx, sy;
    logic [63:0] m;
    sx = longint'(x);
    sy = longint'(y);
    if (s && x[w-1]) sx = sx - (longint'(1) << w);
    if (s && y[w-1]) sy = sy - (longint'(1) << w);
    m = {64{1'b1}} >> (64 - 2*w);
    return 64'(sx * sy) & m;
  endfunction

  // Cycles from start edge to done.
  function automatic int ref_lat(int w, logic [31:0] y);
    int bl;
    bl = 0;
    for (int i = 0; i < w; i++) if (y[i]) bl = i + 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    return (bl + 1 > w) ? w : bl + 1;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Waits for done; optionally pulses start with new operands while busy.
  task automatic wait_done8(input bit disturb, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (disturb && cyc == 2) begin
        start8 = 1'b1; a8 = ~a8; b8 = b8 + 8'd37; sm8 = ~sm8;
      end else if (disturb && cyc == 3) begin
        start8 = 1'b0;
      end
      if (!done8) begin
        chk("busy_mid", {63'd0, busy8}, 64'd1);
        chk("p_clear_busy", {48'd0, p8}, 64'd0);
      end
    end while (!done8 && cyc < 64);
  endtask

  // Called at a negedge; returns at a negedge one cycle after done.
  task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input bit s, input bit disturb);
    logic [63:0] want;
    int el, cyc;
    want = ref_prod(8, {24'd0, x}, {24'd0, y}, s);
    el = ref_lat(8, {24'd0, y});
    a8 = x; b8 = y; sm8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk({tag, "_busy0"}, {63'd0, busy8}, 64'd1);
    chk({tag, "_pclr"}, {48'd0, p8}, 64'd0);
    wait_done8(disturb, cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'(el));
    chk({tag, "_p"}, {48'd0, p8}, want);
    chk({tag, "_excl"}, {63'd0, busy8}, 64'd0);
    @(negedge clk);
    chk({tag, "_hold"}, {48'd0, p8}, want);
    chk({tag, "_pulse"}, {63'd0, done8}, 64'd0);
  endtask

  task automatic run16(input string tag, input logic [15:0] x, input logic [15:0] y, input bit s);
    logic [63:0] want;
    int el, cyc;
    want = ref_prod(16, {16'd0, x}, {16'd0, y}, s);
    el = ref_lat(16, {16'd0, y});
    a16 = x; b16 = y; sm16 = s; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!done16 && cyc < 80);
    chk({tag, "_lat"}, 64'(cyc), 64'(el));
    chk({tag, "_p"}, {32'd0, p16}, want);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    logic [63:0] old;
    reset = 1'b0;
    start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    start16 = 0; sm16 = 0; a16 = 0; b16 = 0;
    repeat (3) @(negedge clk);
    chk("rst_p8", {48'd0, p8}, 64'd0);
    chk("rst_busy8", {63'd0, busy8}, 64'd0);
    chk("rst_done8", {63'd0, done8}, 64'd0);
    chk("rst_p16", {32'd0, p16}, 64'd0);
    chk("rst_busy16", {63'd0, busy16}, 64'd0);
    chk("rst_done16", {63'd0, done16}, 64'd0);

    // Start is driven together with reset release: first edge with reset=1 accepts it.
    reset = 1'b1;
    run8("u255", 8'hFF, 8'hFF, 1'b0, 1'b0);
    chk("u255_const", {48'd0, p8}, 64'hFE01);
    run8("s80", 8'h80, 8'h80, 1'b1, 1'b0);
    chk("s80_const", {48'd0, p8}, 64'h4000);
    run8("sFD", 8'hFD, 8'h05, 1'b1, 1'b0);
    chk("sFD_const", {48'd0, p8}, 64'hFFF1);
    run8("uFD", 8'hFD, 8'h05, 1'b0, 1'b0);
    chk("uFD_const", {48'd0, p8}, 64'h04F1);
    run8("z7F_u", 8'h7F, 8'h00, 1'b0, 1'b0);
    run8("z7F_s", 8'h7F, 8'h00, 1'b1, 1'b0);
    run8("disturb", 8'hB3, 8'h9C, 1'b1, 1'b1);

    // Start held high: ignored in BUSY and DONE, accepted the cycle after done.
    a8 = 8'h12; b8 = 8'h81; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    wait_done8(1'b0, cyc);
    old = ref_prod(8, 32'h12, 32'h81, 1'b0);
    chk("held_lat", 64'(cyc), 64'(ref_lat(8, 32'h81)));
    chk("held_p", {48'd0, p8}, old);
    a8 = 8'h07; b8 = 8'h85;
    @(negedge clk);
    chk("held_idle_busy", {63'd0, busy8}, 64'd0);
    chk("held_idle_done", {63'd0, done8}, 64'd0);
    chk("held_idle_hold", {48'd0, p8}, old);
    @(negedge clk);
    start8 = 1'b0;
    chk("held_accept", {63'd0, busy8}, 64'd1);
    chk("held_accept_p", {48'd0, p8}, 64'd0);
    wait_done8(1'b0, cyc);
    chk("held2_p", {48'd0, p8}, ref_prod(8, 32'h07, 32'h85, 1'b0));
    @(negedge clk);

    // Reset 4 cycles into an operation.
    a8 = 8'h5A; b8 = 8'hC3; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_p", {48'd0, p8}, 64'd0);
    chk("midrst_busy", {63'd0, busy8}, 64'd0);
    chk("midrst_done", {63'd0, done8}, 64'd0);
    reset = 1'b1;
    run8("after_rst", 8'h6B, 8'hE1, 1'b1, 1'b0);

    // Reset clears a held nonzero product.
    reset = 1'b0;
    @(negedge clk);
    chk("rst_hold_p", {48'd0, p8}, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 20; i++)
      run8("rnd8", 8'($urandom), 8'($urandom_range(0, 255) >> $urandom_range(0, 7)),
           1'($urandom), 1'b0);

    run16("s8000", 16'h8000, 16'hFFFF, 1'b1);
    chk("s8000_const", {32'd0, p16}, 64'h8000);
    run16("u16max", 16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 5; i++)
      run16("rnd16", 16'($urandom), 16'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_mult_param.md
SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, meaning synchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, meaning request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port sign_mode, input, 1 bit, meaning 1 = two's-complement operands and 0 = unsigned; latched with start.
REQ-006 The block SHALL have port a, input, WIDTH bits, meaning multiplicand; latched with start.
REQ-007 The block SHALL have port b, input, WIDTH bits, meaning multiplier; latched with start.
REQ-008 The block SHALL have port p, output, 2*WIDTH bits, meaning registered product.
REQ-009 The block SHALL have port busy, output, 1 bit, meaning high while in BUSY.
REQ-010 The block SHALL have port done, output, 1 bit, meaning a one-cycle pulse when p becomes valid.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY and DONE.
- IDLE -> BUSY on start=1.
- BUSY -> DONE after the last bit is processed.
- DONE -> IDLE unconditionally on the next edge.
REQ-012 On the IDLE edge with start=1, the block SHALL latch a, b and sign_mode, clear the accumulator and set the bit counter to 0.
REQ-013 In BUSY, each cycle SHALL process one multiplier bit i (LSB first):
- if the bit is 0: accumulator unchanged;
- if the bit is 1: add the 2*WIDTH-bit extended multiplicand shifted left by i.
REQ-014 Multiplicand extension to 2*WIDTH bits SHALL be sign extension when sign_mode=1 and zero extension when sign_mode=0.
REQ-015 When sign_mode=1 and i=WIDTH-1 with multiplier MSB=1, the shifted multiplicand SHALL be subtracted instead of added.
- Result: the exact two's-complement product, including (-2^(WIDTH-1))^2.
REQ-016 All arithmetic SHALL be modulo 2^(2*WIDTH); no overflow flag exists because the product always fits.
REQ-017 Latency: start sampled at edge N -> p written and DONE entered at edge N+WIDTH; done=1 for exactly that one cycle.
REQ-018 p SHALL hold its value from the DONE edge until the next accepted start, then clear to 0 at that start edge.
REQ-019 start SHALL be ignored in BUSY and in DONE; back-to-back operation therefore accepts start no sooner than the cycle after done.
REQ-020 Inputs a, b and sign_mode SHALL not affect an operation after they are latched.
REQ-021 busy SHALL equal 1 exactly in BUSY, and busy and done SHALL never be high together.

Reset
REQ-022 When reset=0 at a rising clk edge, the block SHALL:
- go to IDLE;
- set p=0, busy=0, done=0, counter=0;
- discard any operation in progress.
REQ-023 Reset SHALL take priority over start in the same cycle.
REQ-024 The first start SHALL be accepted on the first edge with reset=1.

Configuration
REQ-025 With macro SEQ_MULT_EARLY_EXIT_EN defined, the block SHALL enter DONE on the BUSY edge where all multiplier bits at index >= i are 0.
- The product is unchanged by early exit; latency ranges from 1 to WIDTH cycles.
- b=0 gives done one cycle after start.
REQ-026 With SEQ_MULT_EARLY_EXIT_EN undefined, latency SHALL be exactly WIDTH cycles for all operands.

Verification
REQ-027 The bench SHALL cover (WIDTH=8):
- unsigned a=255, b=255 -> p=0xFE01, done exactly 8 cycles after start.
REQ-028 The bench SHALL cover:
- signed a=0x80, b=0x80 -> p=0x4000;
- signed a=0xFD (-3), b=0x05 -> p=0xFFF1;
- unsigned a=0xFD, b=0x05 -> p=0x04F1.
REQ-029 The bench SHALL cover a start pulse during BUSY, with a and b changing -> the result still uses the originally latched operands and busy is unchanged.
REQ-030 The bench SHALL cover reset=0 asserted 4 cycles into an operation -> next cycle p=0, busy=0, done=0; a new start then completes normally.
REQ-031 The bench SHALL cover a=0x7F, b=0x00:
- with the macro: done 1 cycle after start, p=0;
- without the macro: done after 8 cycles, p=0.
REQ-032 The bench SHALL cover WIDTH=16 signed a=0x8000, b=0xFFFF -> p=0x0000_8000 with done after 16 cycles.
